cobi_run_ctrl: RTL and testbench

Job-level sequencer for one COBI chip chain. It accepts a command over a valid/ready handshake, pulses the array-programming engine's start, and waits for that engine's ready to drop and then return. It then holds the chain's anneal enable for a programmable number of cycles, triggers the sample/readout block, and reports completion with a status code. It sits between the host command interface and the programming, anneal and readout datapaths.

---
 rtl/cobi_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cobi_run_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobi_run_ctrl.sv
// Job-level sequencer for one COBI chip chain: program, anneal for N cycles, sample, report status.
// All outputs are registered or decoded from the state register; no input-to-output paths.
module cobi_run_ctrl #(
  parameter int unsigned NUM_CHIPS_PER_CHAIN   = 1,
  parameter int unsigned ANNEAL_CYCLES_DEFAULT = 1000,
  parameter int unsigned PROG_TIMEOUT          = 65536,
  parameter int unsigned SAMPLE_TIMEOUT        = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_anneal_cycles,
  input  logic        abort,
  output logic        prog_start,
  input  logic        prog_ready,
  output logic        anneal_en,
  output logic        sample_start,
  input  logic        sample_done,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status
);

  localparam int unsigned TMO_MAX = (PROG_TIMEOUT > SAMPLE_TIMEOUT) ? PROG_TIMEOUT
                                                                   : SAMPLE_TIMEOUT;
  localparam int unsigned TMO_W   = (TMO_MAX > 2) ? $clog2(TMO_MAX) : 1;

  localparam logic [TMO_W-1:0] PROG_LAST   = TMO_W'(PROG_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] SAMPLE_LAST = TMO_W'(SAMPLE_TIMEOUT - 1);
  localparam logic [15:0]      ANNEAL_DEF  = 16'(ANNEAL_CYCLES_DEFAULT);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] PROG_START  = 3'd1;
  localparam logic [2:0] PROG_WAIT   = 3'd2;
  localparam logic [2:0] ANNEAL      = 3'd3;
  localparam logic [2:0] SAMPLE      = 3'd4;
  localparam logic [2:0] SAMPLE_WAIT = 3'd5;
  localparam logic [2:0] DONE        = 3'd6;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_PROG_TMO = 2'd1;
  localparam logic [1:0] ST_SAMP_TMO = 2'd2;
  localparam logic [1:0] ST_ABORT    = 2'd3;

  if (NUM_CHIPS_PER_CHAIN < 1 || ANNEAL_CYCLES_DEFAULT < 1 || ANNEAL_CYCLES_DEFAULT > 65535 ||
      PROG_TIMEOUT < 1 || SAMPLE_TIMEOUT < 1) begin : g_param_check
    $error("cobi_run_ctrl: illegal parameter value");
  end

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      anneal_cnt_q, anneal_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             seen_low_q, seen_low_d;
  logic [1:0]       status_q, status_d;
  logic [15:0]      anneal_len;

  assign anneal_len = (cmd_anneal_cycles == 16'd0) ? ANNEAL_DEF : cmd_anneal_cycles;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    anneal_cnt_d = anneal_cnt_q;
    tmo_d        = tmo_q;
    seen_low_d   = seen_low_q;
    status_d     = status_q;
    // Abort outranks any completion or timeout seen in the same cycle.
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d  = DONE;
      status_d = ST_ABORT;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_d         = cmd_op;
            anneal_cnt_d = anneal_len - 16'd1;
            status_d     = ST_OK;
            case (cmd_op)
              2'd1:    state_d = ANNEAL;
              2'd3: begin
                state_d  = DONE;
                status_d = ST_ABORT;
              end
              default: state_d = PROG_START;
            endcase
          end
        end
        PROG_START: begin
          state_d    = PROG_WAIT;
          tmo_d      = '0;
          seen_low_d = 1'b0;
        end
        PROG_WAIT: begin
          if (!prog_ready) seen_low_d = 1'b1;
          // Ready is trusted only after it has been seen low since the start pulse.
          if (seen_low_q && prog_ready) begin
            if (op_q == 2'd2) begin
              state_d = ANNEAL;
            end else begin
              state_d  = DONE;
              status_d = ST_OK;
            end
          end else if (tmo_q == PROG_LAST) begin
            state_d  = DONE;
            status_d = ST_PROG_TMO;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ANNEAL: begin
          if (anneal_cnt_q == 16'd0) state_d = SAMPLE;
          else anneal_cnt_d = anneal_cnt_q - 16'd1;
        end
        SAMPLE: begin
          state_d = SAMPLE_WAIT;
          tmo_d   = '0;
        end
        SAMPLE_WAIT: begin
          if (sample_done) begin
            state_d  = DONE;
            status_d = ST_OK;
          end else if (tmo_q == SAMPLE_LAST) begin
            state_d  = DONE;
            status_d = ST_SAMP_TMO;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 2'd0;
      anneal_cnt_q <= 16'd0;
      tmo_q        <= '0;
      seen_low_q   <= 1'b0;
      status_q     <= ST_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      anneal_cnt_q <= anneal_cnt_d;
      tmo_q        <= tmo_d;
      seen_low_q   <= seen_low_d;
      status_q     <= status_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign prog_start   = (state_q == PROG_START);
  assign anneal_en    = (state_q == ANNEAL);
  assign sample_start = (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign status       = status_q;

endmodule

// File: tb/tb_cobi_run_ctrl.sv
// Directed bench for cobi_run_ctrl: a short-timeout instance for most cases and a
// default-parameter instance for the long programming + 1000-cycle anneal job.
module tb_cobi_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_anneal_cycles;
  logic        abort;
  logic        prog_ready;
  logic        sample_done;

  logic        a_cmd_ready, a_prog_start, a_anneal_en, a_sample_start, a_busy, a_done;
  logic [1:0]  a_status;
  logic        l_cmd_ready, l_prog_start, l_anneal_en, l_sample_start, l_busy, l_done;
  logic [1:0]  l_status;

  logic        sel;
  logic        s_cmd_ready, s_prog_start, s_anneal_en, s_sample_start, s_busy, s_done;
  logic [1:0]  s_status;

  int checks   = 0;
  int failures = 0;
  int n_an, n_ss, n_ps, t_an, t_ss, t_done, st_done, busy_after, ready_after, hs;

  always #5 clk = ~clk;

  cobi_run_ctrl #(
    .NUM_CHIPS_PER_CHAIN  (1),
    .ANNEAL_CYCLES_DEFAULT(1000),
    .PROG_TIMEOUT         (16),
    .SAMPLE_TIMEOUT       (8)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (a_cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_anneal_cycles(cmd_anneal_cycles),
    .abort            (abort),
    .prog_start       (a_prog_start),
    .prog_ready       (prog_ready),
    .anneal_en        (a_anneal_en),
    .sample_start     (a_sample_start),
    .sample_done      (sample_done),
    .busy             (a_busy),
    .done             (a_done),
    .status           (a_status)
  );

  cobi_run_ctrl u_long (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (l_cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_anneal_cycles(cmd_anneal_cycles),
    .abort            (abort),
    .prog_start       (l_prog_start),
    .prog_ready       (prog_ready),
    .anneal_en        (l_anneal_en),
    .sample_start     (l_sample_start),
    .sample_done      (sample_done),
    .busy             (l_busy),
    .done             (l_done),
    .status           (l_status)
  );

  assign s_cmd_ready    = sel ? l_cmd_ready    : a_cmd_ready;
  assign s_prog_start   = sel ? l_prog_start   : a_prog_start;
  assign s_anneal_en    = sel ? l_anneal_en    : a_anneal_en;
  assign s_sample_start = sel ? l_sample_start : a_sample_start;
  assign s_busy         = sel ? l_busy         : a_busy;
  assign s_done         = sel ? l_done         : a_done;
  assign s_status       = sel ? l_status       : a_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; sample_done = 1'b0; prog_ready = 1'b1;
    cmd_op = 2'd0; cmd_anneal_cycles = 16'd0; sel = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] n);
    cmd_op = op; cmd_anneal_cycles = n; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Watches one job from the cycle after accept (i = 1) to the cycle after done.
  // sd: SAMPLE_WAIT cycle (1-based) in which sample_done rises, -1 = never.
  // prog_low: cycles prog_ready stays low after one stale-high cycle, -1 = stuck high.
  // abort_at: anneal cycle in which abort is raised, 0 = none.
  task automatic run_job(input int budget, input int sd, input int prog_low, input int abort_at);
    int  k_ps, k_ss;
    bit  fin;
    n_an = 0; n_ss = 0; n_ps = 0; t_an = -1; t_ss = -1; t_done = -1; st_done = -1;
    k_ps = -1; k_ss = -1; fin = 1'b0;
    for (int i = 1; i <= budget && !fin; i++) begin
      abort = 1'b0;
      if (s_anneal_en) begin
        n_an++;
        if (t_an < 0) t_an = i;
        if (abort_at > 0 && n_an == abort_at) abort = 1'b1;
      end
      if (s_prog_start) begin
        n_ps++;
        k_ps = 0;
      end else if (k_ps >= 0) begin
        k_ps++;
      end
      if (prog_low < 0) prog_ready = 1'b1;
      else prog_ready = !(k_ps >= 2 && k_ps <= prog_low + 1);
      if (s_sample_start) begin
        n_ss++;
        t_ss = i;
        k_ss = 0;
      end else if (k_ss >= 0) begin
        k_ss++;
      end
      sample_done = (sd >= 0 && k_ss >= sd);
      if (s_done) begin
        t_done  = i;
        st_done = int'(s_status);
        fin     = 1'b1;
      end
      step();
    end
    abort = 1'b0; sample_done = 1'b0; prog_ready = 1'b1;
    busy_after  = int'(s_busy);
    ready_after = int'(s_cmd_ready);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_cmd_ready", a_cmd_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_anneal_en", a_anneal_en, 0);
    chk("rst_done", a_done, 0);
    chk("rst_status", a_status, 0);
    chk("rst_prog_start", a_prog_start, 0);
    chk("rst_sample_start", a_sample_start, 0);

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", a_busy, 0);
    chk("idle_abort_done", a_done, 0);

    // 1: op 1, N = 5, sample_done in the 3rd wait cycle.
    issue(2'd1, 16'd5);
    run_job(60, 3, -1, 0);
    chk("t1_first_anneal", t_an, 1);
    chk("t1_anneal_cycles", n_an, 5);
    chk("t1_sample_start_at", t_ss, 6);
    chk("t1_sample_starts", n_ss, 1);
    chk("t1_prog_starts", n_ps, 0);
    chk("t1_done_at", t_done, 10);
    chk("t1_status", st_done, 0);
    chk("t1_busy_after", busy_after, 0);
    chk("t1_ready_after", ready_after, 1);

    // 2: op 2, default anneal length, stale ready then 20 low cycles (default instance).
    do_reset();
    sel = 1'b1;
    issue(2'd2, 16'd0);
    run_job(1200, 1, 20, 0);
    chk("t2_prog_starts", n_ps, 1);
    chk("t2_first_anneal", t_an, 24);
    chk("t2_anneal_cycles", n_an, 1000);
    chk("t2_sample_start_at", t_ss, 1024);
    chk("t2_done_at", t_done, 1026);
    chk("t2_status", st_done, 0);
    sel = 1'b0;

    // 3: op 0 with ready stuck high -> program timeout after 16 PROG_WAIT cycles.
    do_reset();
    issue(2'd0, 16'd4);
    run_job(60, -1, -1, 0);
    chk("t3_prog_starts", n_ps, 1);
    chk("t3_done_at", t_done, 18);
    chk("t3_status", st_done, 1);
    chk("t3_anneal_cycles", n_an, 0);

    // 4: sample_done on the timeout cycle wins; no sample_done -> sample timeout.
    do_reset();
    issue(2'd1, 16'd1);
    run_job(60, 8, -1, 0);
    chk("t4a_done_at", t_done, 11);
    chk("t4a_status", st_done, 0);
    do_reset();
    issue(2'd1, 16'd1);
    run_job(60, -1, -1, 0);
    chk("t4b_done_at", t_done, 11);
    chk("t4b_status", st_done, 2);

    // 5: abort in the 3rd of 10 anneal cycles; then a reserved op.
    do_reset();
    issue(2'd1, 16'd10);
    run_job(60, 1, -1, 3);
    chk("t5_anneal_cycles", n_an, 3);
    chk("t5_done_at", t_done, 4);
    chk("t5_status", st_done, 3);
    chk("t5_sample_starts", n_ss, 0);
    issue(2'd3, 16'd7);
    run_job(20, 1, -1, 0);
    chk("t5_op3_done_at", t_done, 1);
    chk("t5_op3_status", st_done, 3);
    chk("t5_op3_anneal", n_an, 0);
    chk("t5_op3_prog", n_ps, 0);

    // 6: command held through busy, reset mid-anneal, held command accepted once after.
    do_reset();
    hs = 0;
    cmd_op = 2'd1; cmd_anneal_cycles = 16'd10; cmd_valid = 1'b1;
    if (a_cmd_ready && cmd_valid) hs++;
    step();
    for (int i = 0; i < 4; i++) begin
      if (a_cmd_ready && cmd_valid) hs++;
      step();
    end
    chk("t6_held_accepts", hs, 1);
    chk("t6_busy_ready", a_cmd_ready, 0);
    chk("t6_mid_anneal", a_anneal_en, 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_anneal_en", a_anneal_en, 0);
    chk("t6_rst_cmd_ready", a_cmd_ready, 1);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_done", a_done, 0);
    #2 rst = 1'b0;
    if (a_cmd_ready && cmd_valid) hs++;
    step();
    cmd_valid = 1'b0;
    run_job(60, 1, -1, 0);
    chk("t6_total_accepts", hs, 2);
    chk("t6_anneal_cycles", n_an, 10);
    chk("t6_sample_start_at", t_ss, 11);
    chk("t6_done_at", t_done, 13);
    chk("t6_status", st_done, 0);
    step();
    step();
    chk("t6_idle_busy", a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
